// File: rtl/serial_adder_pkg.sv
// +----------------------------------------------------------------------+
// | serial_adder_pkg                                                     |
// | Shared FSM state encoding and sizing helper for serial_adder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// +----------------------------------------------------------------------+
// | full_adder                                                           |
// | Single-bit full adder cell, ripple-chained by serial_adder.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ ci;
    assign carry = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// +----------------------------------------------------------------------+
// | serial_adder                                                         |
// | Multi-cycle add/subtract, DIGIT bits per clock over WIDTH bits.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS + 1);
    localparam logic [CW-1:0] c_last_step = CW'(STEPS - 1);
    localparam logic [CW-1:0] c_load_step = CW'(STEPS);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_work;
    logic             r_c;
    logic             r_cmsb;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_digit;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_opa_next;
    logic [WIDTH-1:0] w_opb_next;

    assign w_c[0] = r_c;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_chain
            full_adder u_fa (
                .a     (r_opa[i]),
                .b     (r_opb[i]),
                .ci    (w_c[i]),
                .sum   (w_digit[i]),
                .carry (w_c[i+1])
            );
        end

        if (DIGIT == WIDTH) begin : g_single_step
            assign w_work_next = w_digit;
            assign w_opa_next  = '0;
            assign w_opb_next  = '0;
        end else begin : g_multi_step
            assign w_work_next = {w_digit, r_work[WIDTH-1:DIGIT]};
            assign w_opa_next  = {{DIGIT{1'b0}}, r_opa[WIDTH-1:DIGIT]};
            assign w_opb_next  = {{DIGIT{1'b0}}, r_opb[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_work   <= '0;
            r_c      <= 1'b0;
            r_cmsb   <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_c     <= ci ^ sub;
                        r_cnt   <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Steps 0..STEPS-1 compute; the extra step publishes the result.
                    if (r_cnt == c_load_step) begin
                        sum      <= r_work;
                        carry    <= r_c;
                        overflow <= r_c ^ r_cmsb;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_work <= w_work_next;
                        r_opa  <= w_opa_next;
                        r_opb  <= w_opb_next;
                        r_c    <= w_c[DIGIT];
                        r_cnt  <= r_cnt + CW'(1);
                        if (r_cnt == c_last_step) begin
                            r_cmsb <= w_c[DIGIT-1];
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// +----------------------------------------------------------------------+
// | tb_serial_adder                                                      |
// | Directed + random checks of three serial_adder configurations.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic [2:0] st;
    logic       sub;
    logic       ci;
    logic [7:0] a;
    logic [7:0] b;

    logic [2:0] rdy, bsy, dn, cy, ov;
    logic [7:0] s0, s1;
    logic [3:0] s2;

    int vectors;
    int miscompares;

    // d0: WIDTH=8 DIGIT=1, d1: WIDTH=8 DIGIT=4, d2: WIDTH=4 DIGIT=1
    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .reset(reset), .start(st[0]), .sub(sub), .a(a), .b(b), .ci(ci),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(s0), .carry(cy[0]), .overflow(ov[0])
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d1 (
        .clk(clk), .reset(reset), .start(st[1]), .sub(sub), .a(a), .b(b), .ci(ci),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(s1), .carry(cy[1]), .overflow(ov[1])
    );
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_d2 (
        .clk(clk), .reset(reset), .start(st[2]), .sub(sub), .a(a[3:0]), .b(b[3:0]), .ci(ci),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .sum(s2), .carry(cy[2]), .overflow(ov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sum_of(input int d);
        case (d)
            0:       return s0;
            1:       return s1;
            default: return {4'b0, s2};
        endcase
    endfunction

    function automatic int width_of(input int d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic int steps_of(input int d);
        return (d == 1) ? 2 : width_of(d);
    endfunction

    // Plain-arithmetic reference: unsigned result for sum/carry, signed range for overflow.
    task automatic model(input int w, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tci, input logic tsub,
                         output logic [7:0] es, output logic ec, output logic eo);
        int m, ua, ub, sa, sb, r, sr;
        m  = (1 << w) - 1;
        ua = int'(ta) & m;
        ub = int'(tb_) & m;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        if (tsub) begin
            r  = ua - ub - int'(tci);
            sr = sa - sb - int'(tci);
            ec = (r >= 0);
        end else begin
            r  = ua + ub + int'(tci);
            sr = sa + sb + int'(tci);
            ec = ((r >> w) & 1) == 1;
        end
        es = 8'(r & m);
        eo = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation on DUT d; intrude>0 fires a competing start with other operands mid-RUN.
    task automatic run_op(input int d, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tci, input logic tsub, input int intrude);
        logic [7:0] es;
        logic       ec, eo;
        int         steps, got;
        steps = steps_of(d);
        model(width_of(d), ta, tb_, tci, tsub, es, ec, eo);
        @(negedge clk);
        a = ta; b = tb_; ci = tci; sub = tsub; st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
        got = 0;
        for (int n = 1; n <= steps + 6 && got == 0; n++) begin
            @(negedge clk);
            if (intrude > 0 && n == intrude + 1) st[d] = 1'b0;
            if (dn[d]) begin
                got = n;
            end else if (intrude > 0 && n <= steps) begin
                chk("busy_in_run", 32'(bsy[d]), 32'd1);
                chk("ready_in_run", 32'(rdy[d]), 32'd0);
            end
            if (intrude > 0 && n == intrude) begin
                a = ~ta; b = ~tb_; ci = ~tci; sub = ~tsub; st[d] = 1'b1;
            end
        end
        chk("latency", 32'(got), 32'(steps + 1));
        chk("sum", 32'(sum_of(d)), 32'(es));
        chk("carry", 32'(cy[d]), 32'(ec));
        chk("overflow", 32'(ov[d]), 32'(eo));
        @(negedge clk);
        chk("done_one_cycle", 32'(dn[d]), 32'd0);
        chk("ready_after", 32'(rdy[d]), 32'd1);
        st = '0;
    endtask

    initial begin
        int seen;
        vectors = 0; miscompares = 0;
        reset = 1'b1; st = '0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd1);
            chk("reset_busy", 32'(bsy[d]), 32'd0);
            chk("reset_done", 32'(dn[d]), 32'd0);
            chk("reset_sum", 32'(sum_of(d)), 32'd0);
            chk("reset_flags", 32'({cy[d], ov[d]}), 32'd0);
        end
        reset = 1'b0;

        run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 0);
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 0);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 3);

        // Abort: reset three cycles into RUN.
        @(negedge clk);
        a = 8'hC3; b = 8'h11; ci = 1'b1; sub = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_sum", 32'(s0), 32'd0);
        chk("abort_flags", 32'({dn[0], cy[0], ov[0]}), 32'd0);
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (dn[0]) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        for (int i = 0; i < 200; i++) begin
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'(i % 2), 0);
        end

        $monitor("t=%0t d2 done=%b sum=%h carry=%b ovf=%b", $time, dn[2], s2, cy[2], ov[2]);
        for (int k = 0; k < 1024; k++) begin
            run_op(2, 8'(k & 15), 8'((k >> 4) & 15), 1'((k >> 8) & 1), 1'((k >> 9) & 1), 0);
        end
        $monitoroff;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
